// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration controller.
// Holds the management-slave word addresses, the STATUS done-bit index
// and the controller state type.
package pll_reconfig_pkg;

  localparam logic [5:0] REG_MODE   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_START  = 6'h02;
  localparam logic [5:0] REG_N      = 6'h03;
  localparam logic [5:0] REG_M      = 6'h04;
  localparam logic [5:0] REG_C      = 6'h05;

  localparam int unsigned STATUS_DONE_BIT = 0;

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_M,
    WR_N,
    WR_C,
    WR_START,
    RD_STATUS,
    POLL_GAP,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/pll_reconfig_avm_xfer.sv
// Single Avalon-MM transfer engine.
// go (one cycle) loads rnw/addr/data into the registered bus outputs and
// raises the strobe; the transfer is held until waitrequest drops.
// xfer_done pulses in the completion cycle; rdata is the slave read data,
// meaningful only when xfer_done is high on a read.
// Ports: clk, rst_n (async active-low), go, rnw, addr[5:0], data[31:0],
//        avm_address[5:0], avm_read, avm_write, avm_writedata[31:0],
//        avm_readdata[31:0], avm_waitrequest, xfer_done, rdata[31:0].
import pll_reconfig_pkg::*;

module pll_reconfig_avm_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        rnw,
  input  logic [5:0]  addr,
  input  logic [31:0] data,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        xfer_done,
  output logic [31:0] rdata
);

  assign xfer_done = (avm_read | avm_write) & ~avm_waitrequest;
  assign rdata     = avm_readdata;

  // go has priority so a new transfer can start on the same edge the
  // previous one completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else if (go) begin
      avm_address   <= addr;
      avm_read      <= rnw;
      avm_write     <= ~rnw;
      avm_writedata <= rnw ? '0 : data;
    end else if (xfer_done) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: Avalon-MM master for the pll_reconfig
// mgmt_avalon_slave. Accepts one M/N/C request, writes MODE, M, N, C and
// START, then polls STATUS until done or until the poll timeout expires.
// Ports: clk_clk, reset_reset_n (async active-low), cfg_valid/cfg_ready
//        request handshake, cfg_m/cfg_n/cfg_c counter values, avm_* master
//        bus, done / error one-cycle completion pulses.
import pll_reconfig_pkg::*;

module pll_reconfig_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] MODE_POLL      = 32'd1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_n,
  input  logic [22:0] cfg_c,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        done,
  output logic        error
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [31:0]      m_q, n_q, c_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             go, rnw;
  logic [5:0]       addr;
  logic [31:0]      wdata;
  logic             xfer_done;
  logic [31:0]      rdata;
  logic             status_done;
  logic             unused_rdata;

  assign status_done  = rdata[STATUS_DONE_BIT];
  assign unused_rdata = ^rdata[31:1];

  assign cfg_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cfg_valid) begin
        m_q <= {14'b0, cfg_m};
        n_q <= {14'b0, cfg_n};
        c_q <= {9'b0, cfg_c};
      end
      if (state == WR_START && next_state == RD_STATUS) begin
        tmo_cnt <= '0;
      end else if ((state == RD_STATUS || state == POLL_GAP) && tmo_cnt != CNT_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Transfer parameters are decoded from next_state so that the registered
  // bus outputs are valid in the first cycle of each transfer state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cfg_valid) next_state = WR_MODE;
      WR_MODE:   if (xfer_done) next_state = WR_M;
      WR_M:      if (xfer_done) next_state = WR_N;
      WR_N:      if (xfer_done) next_state = WR_C;
      WR_C:      if (xfer_done) next_state = WR_START;
      WR_START:  if (xfer_done) next_state = RD_STATUS;
      RD_STATUS: begin
        if (xfer_done) begin
          if (status_done)            next_state = DONE;
          else if (tmo_cnt >= CNT_MAX) next_state = ERROR;
          else                         next_state = POLL_GAP;
        end
      end
      POLL_GAP:  next_state = RD_STATUS;
      DONE:      next_state = IDLE;
      ERROR:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase

    rnw   = 1'b0;
    addr  = '0;
    wdata = '0;
    case (next_state)
      WR_MODE:   begin addr = REG_MODE;  wdata = MODE_POLL; end
      WR_M:      begin addr = REG_M;     wdata = m_q;       end
      WR_N:      begin addr = REG_N;     wdata = n_q;       end
      WR_C:      begin addr = REG_C;     wdata = c_q;       end
      WR_START:  begin addr = REG_START; wdata = 32'd1;     end
      RD_STATUS: begin addr = REG_STATUS; rnw = 1'b1;       end
      default:   ;
    endcase

    go = (next_state != state) &&
         (next_state inside {WR_MODE, WR_M, WR_N, WR_C, WR_START, RD_STATUS});
  end

  pll_reconfig_avm_xfer u_xfer (
    .clk             (clk_clk),
    .rst_n           (reset_reset_n),
    .go              (go),
    .rnw             (rnw),
    .addr            (addr),
    .data            (wdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .xfer_done       (xfer_done),
    .rdata           (rdata)
  );

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl with a transaction-level model:
// each accepted request expands into an ordered write list, a read count
// and a completion cycle derived from stall/poll/timeout arithmetic.
module tb_pll_reconfig_ctrl;

  localparam int TMO = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] cfg_m, cfg_n;
  logic [22:0] cfg_c;
  logic [5:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        done, error;

  pll_reconfig_ctrl #(.TIMEOUT_CYCLES(TMO), .MODE_POLL(32'd1)) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_m           (cfg_m),
    .cfg_n           (cfg_n),
    .cfg_c           (cfg_c),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .done            (done),
    .error           (error)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  int  cur = 0;
  bit  run_active = 0;
  int  hs, exp_end, exp_ws, exp_r;
  bit  exp_is_err;
  wr_t wq[$];
  int  runs_started = 0;
  // Slave configuration
  int  stall_addr = -1, stall_rem = 0, n_zero = 0, reads_done = 0;
  // Observations of the last run
  int  obs_done_rel, obs_err_rel, obs_ready_rel, obs_reads, obs_stall_cycles;
  // Previous-cycle bus snapshot
  bit          prev_stall = 0;
  logic [5:0]  p_addr;
  logic [31:0] p_data;
  logic        p_rd, p_wr;

  always @(posedge clk_clk) cur <= cur + 1;

  task automatic start_run();
    int r_to, cnt;
    wr_t w;
    hs = cur;
    run_active = 1;
    runs_started++;
    wq.delete();
    w.addr = 6'h00; w.data = 32'd1;           wq.push_back(w);
    w.addr = 6'h04; w.data = {14'b0, cfg_m};  wq.push_back(w);
    w.addr = 6'h03; w.data = {14'b0, cfg_n};  wq.push_back(w);
    w.addr = 6'h05; w.data = {9'b0, cfg_c};   wq.push_back(w);
    w.addr = 6'h02; w.data = 32'd1;           wq.push_back(w);
    // Poll j sees the count min(2j, TMO-1); the read where it reaches
    // TMO-1 is the last one before giving up.
    r_to = 0;
    do begin
      cnt = (2 * r_to < TMO - 1) ? 2 * r_to : TMO - 1;
      r_to++;
    end while (cnt < TMO - 1);
    if (n_zero < r_to) begin exp_r = n_zero + 1; exp_is_err = 0; end
    else               begin exp_r = r_to;       exp_is_err = 1; end
    exp_ws  = 5 + stall_rem;
    exp_end = exp_ws + 2 * exp_r;
    reads_done = 0;
    obs_done_rel = -1; obs_err_rel = -1; obs_ready_rel = -1;
    obs_reads = 0; obs_stall_cycles = 0;
  endtask

  always @(negedge clk_clk) begin
    int rel;
    bit strobe, exp_st;
    if (!reset_reset_n) begin
      run_active = 0;
      wq.delete();
      prev_stall = 0;
      stall_rem = 0;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
    end else begin
      strobe = avm_read || avm_write;
      avm_waitrequest = 1'b0;
      if (strobe && stall_rem > 0 && int'(avm_address) == stall_addr) begin
        avm_waitrequest = 1'b1;
        stall_rem--;
      end
      avm_readdata = (reads_done < n_zero) ? 32'hA5A5_F0F0 : 32'h5A5A_0F0F;

      chk("rd_wr_exclusive", 32'(avm_read & avm_write), 0);
      if (prev_stall) begin
        chk("hold_addr", avm_address, p_addr);
        chk("hold_data", avm_writedata, p_data);
        chk("hold_read", avm_read, p_rd);
        chk("hold_write", avm_write, p_wr);
      end

      if (run_active) begin
        rel = cur - hs;
        exp_st = (rel >= 1 && rel <= exp_ws) ||
                 (rel > exp_ws && rel <= exp_ws + 2 * exp_r - 1 && ((rel - exp_ws - 1) % 2 == 0));
        chk("strobe", strobe, exp_st);
        chk("done", done, !exp_is_err && rel == exp_end);
        chk("error", error, exp_is_err && rel == exp_end);
        chk("cfg_ready", cfg_ready, rel == exp_end + 1);
        if (done && obs_done_rel < 0) obs_done_rel = rel;
        if (error && obs_err_rel < 0) obs_err_rel = rel;
        if (cfg_ready && obs_ready_rel < 0) obs_ready_rel = rel;
        if (strobe && int'(avm_address) == stall_addr) obs_stall_cycles++;
        if (avm_write) begin
          if (wq.size() == 0) chk("unexpected_write", avm_write, 0);
          else begin
            chk("wr_addr", avm_address, wq[0].addr);
            chk("wr_data", avm_writedata, wq[0].data);
            if (!avm_waitrequest) void'(wq.pop_front());
          end
        end
        if (avm_read) begin
          chk("rd_addr", avm_address, 6'h01);
          if (!avm_waitrequest) begin reads_done++; obs_reads++; end
        end
        if (rel == exp_end + 1) begin
          chk("writes_left", wq.size(), 0);
          run_active = 0;
        end
      end else begin
        chk("idle_strobe", strobe, 0);
        chk("idle_done", done, 0);
        chk("idle_error", error, 0);
        chk("idle_ready", cfg_ready, 1);
      end

      prev_stall = strobe && avm_waitrequest;
      p_addr = avm_address; p_data = avm_writedata;
      p_rd = avm_read; p_wr = avm_write;

      if (!run_active && cfg_valid) start_run();
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (run_active && k < 500) begin
      @(posedge clk_clk); #1;
      k++;
    end
    if (run_active) chk("run_bound", run_active, 0);
  endtask

  task automatic do_run(input logic [17:0] m, input logic [17:0] n, input logic [22:0] c,
                        input int sa, input int sn, input int nz);
    @(posedge clk_clk); #1;
    stall_addr = sa; stall_rem = sn; n_zero = nz;
    cfg_m = m; cfg_n = n; cfg_c = c;
    cfg_valid = 1'b1;
    @(posedge clk_clk); #1;
    cfg_valid = 1'b0;
    cfg_m = ~m; cfg_n = ~n; cfg_c = ~c;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    int start;
    bit found;
    reset_reset_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_c = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    #12;
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", cfg_ready, 1);
    #10 reset_reset_n = 1'b1;

    // Plain run: done at cycle 7, ready at cycle 8.
    do_run(18'h2_5A5A, 18'h1_2345, 23'h4A_BCDE, -1, 0, 0);
    chk("t1_done_rel", obs_done_rel, 7);
    chk("t1_ready_rel", obs_ready_rel, 8);
    chk("t1_err_rel", obs_err_rel, -1);
    chk("t1_reads", obs_reads, 1);

    // Three stall cycles on the N write.
    do_run(18'h0_0F0F, 18'h3_FFFF, 23'h7F_FFFF, 3, 3, 0);
    chk("t2_done_rel", obs_done_rel, 10);
    chk("t2_ready_rel", obs_ready_rel, 11);
    chk("t2_n_cycles", obs_stall_cycles, 4);

    // Status 0, 0, then 1.
    do_run(18'h1_1111, 18'h2_2222, 23'h33_3333, -1, 0, 2);
    chk("t3_reads", obs_reads, 3);
    chk("t3_done_rel", obs_done_rel, 11);
    chk("t3_err_rel", obs_err_rel, -1);

    // Status never done: timeout.
    do_run(18'h0_0001, 18'h0_0002, 23'h00_0003, -1, 0, 1000);
    chk("t4_err_rel", obs_err_rel, 23);
    chk("t4_done_rel", obs_done_rel, -1);
    chk("t4_reads", obs_reads, 9);
    do_run(18'h3_0003, 18'h0_3000, 23'h05_0505, -1, 0, 0);
    chk("t4b_done_rel", obs_done_rel, 7);

    // cfg_valid held with changing cfg_m.
    @(posedge clk_clk); #1;
    start = runs_started;
    stall_addr = -1; stall_rem = 0; n_zero = 0;
    cfg_n = 18'h0_ABCD; cfg_c = 23'h12_3456;
    cfg_m = 18'h0_0111; cfg_valid = 1'b1;
    for (int k = 0; k < 100 && runs_started < start + 2; k++) begin
      @(posedge clk_clk); #1;
      cfg_m = cfg_m + 18'h0_1011;
    end
    cfg_valid = 1'b0;
    wait_idle();
    chk("t5_runs", runs_started - start, 2);
    chk("t5_done_rel", obs_done_rel, 7);

    // Reset during the stalled C write.
    @(posedge clk_clk); #1;
    stall_addr = 5; stall_rem = 10; n_zero = 0;
    cfg_m = 18'h1_0001; cfg_n = 18'h2_0002; cfg_c = 23'h40_0004;
    cfg_valid = 1'b1;
    @(posedge clk_clk); #1;
    cfg_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_clk); #1;
      if (avm_write && avm_address == 6'h05 && avm_waitrequest) found = 1;
    end
    chk("t6_stall_seen", found, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("t6_write", avm_write, 0);
    chk("t6_read", avm_read, 0);
    chk("t6_addr", avm_address, 0);
    chk("t6_wdata", avm_writedata, 0);
    chk("t6_done", done, 0);
    chk("t6_error", error, 0);
    chk("t6_ready", cfg_ready, 1);
    @(posedge clk_clk); @(posedge clk_clk); #3;
    reset_reset_n = 1'b1;
    @(negedge clk_clk); #1;
    chk("t6_ready_after", cfg_ready, 1);
    do_run(18'h2_AAAA, 18'h1_5555, 23'h2A_AAAA, -1, 0, 0);
    chk("t6b_done_rel", obs_done_rel, 7);

    repeat (3) @(posedge clk_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
